// File: rtl/polynomial_encoder_if.sv
// polynomial_encoder_if: control, poly RAM read and byte RAM write signals
interface polynomial_encoder_if;
   logic        start;
   logic        busy;
   logic        done;
   logic [8:0]  poly_addra;
   logic [15:0] poly_doa;
   logic        byte_wea;
   logic [9:0]  byte_addr;
   logic [7:0]  byte_di;
   modport master (output start, poly_doa, input busy, done, poly_addra, byte_wea, byte_addr, byte_di);
   modport slave (input start, poly_doa, output busy, done, poly_addra, byte_wea, byte_addr, byte_di);
endinterface

// File: rtl/polynomial_encoder.sv
// polynomial_encoder: freezes 512 coefficients to [0,Q) and packs each group of 4 into 7 bytes
module polynomial_encoder #(
   parameter int Q      = 12289,
   parameter bit FREEZE = 1
) (
   input logic clk,
   input logic rst,
   polynomial_encoder_if.slave bus
);
   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, FINAL} state_t;
   state_t      state;
   logic [6:0]  i;
   logic [1:0]  k;
   logic [2:0]  j;
   logic [13:0] t [4];
   logic [13:0] c, f;
   logic [55:0] pk;
   logic [2:0]  jn;
   logic [7:0]  nb;
   always_comb begin
      c  = bus.poly_doa[13:0];
      f  = (FREEZE && c >= 14'(Q)) ? c - 14'(Q) : c;
      pk = {t[3], t[2], t[1], t[0]};
      jn = j + 3'd1;
      nb = 8'(pk >> {jn, 3'b000});
   end
   // read data trails its address by one cycle, so t[k-1] is captured while address k is out
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         i              <= '0;
         k              <= '0;
         j              <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.poly_addra <= '0;
         bus.byte_wea   <= 1'b0;
         bus.byte_addr  <= '0;
         bus.byte_di    <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state          <= FETCH;
               k              <= '0;
               bus.busy       <= 1'b1;
               bus.poly_addra <= {i, 2'b00};
            end
            FETCH: begin
               if (k != 2'd0) t[k - 2'd1] <= f;
               if (k == 2'd3) begin
                  state          <= CAPTURE;
                  bus.poly_addra <= '0;
               end else begin
                  k              <= k + 2'd1;
                  bus.poly_addra <= {i, k + 2'd1};
               end
            end
            CAPTURE: begin
               t[3]          <= f;
               state         <= WRITE;
               j             <= '0;
               bus.byte_wea  <= 1'b1;
               bus.byte_addr <= 10'(i) * 10'd7;
               bus.byte_di   <= t[0][7:0];
            end
            WRITE: begin
               if (j == 3'd6) begin
                  bus.byte_wea  <= 1'b0;
                  bus.byte_addr <= '0;
                  bus.byte_di   <= '0;
                  if (i == 7'd127) begin
                     state    <= FINAL;
                     bus.done <= 1'b1;
                     bus.busy <= 1'b0;
                  end else begin
                     i              <= i + 7'd1;
                     k              <= '0;
                     state          <= FETCH;
                     bus.poly_addra <= {i + 7'd1, 2'b00};
                  end
               end else begin
                  j             <= jn;
                  bus.byte_addr <= bus.byte_addr + 10'd1;
                  bus.byte_di   <= nb;
               end
            end
            FINAL: begin
               bus.done <= 1'b0;
               i        <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_polynomial_encoder.sv
// tb_polynomial_encoder: random and directed encodes checked against a bit-stream packing model
module tb_polynomial_encoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   polynomial_encoder_if bus();
   polynomial_encoder #(.Q(12289), .FREEZE(1)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   logic [15:0] mem [512];
   logic [7:0]  got [896];
   logic [7:0]  expb [896];
   int total = 0;
   int bad = 0;
   always @(posedge clk) bus.poly_doa <= mem[bus.poly_addra];
   function automatic int frz(int c);
      return c % 12289;
   endfunction
   // little-endian 14-bit stream of frozen coefficients, cut into bytes
   task automatic build_ref();
      for (int b = 0; b < 896; b++) begin
         logic [7:0] v;
         int p;
         v = '0;
         for (int m = 0; m < 8; m++) begin
            p = 8 * b + m;
            v[m] = 1'((frz(int'(mem[p / 14][13:0])) >> (p % 14)) & 1);
         end
         expb[b] = v;
      end
   endtask
   function automatic int wcycle(int a);
      return 6 + 12 * (a / 7) + a % 7;
   endfunction
   task automatic run(input string name, input int restart_at, input int abort_at, input bit start_in_final);
      int n, wc, dc, dones, lim, wexp;
      bit fin;
      build_ref();
      lim = abort_at > 0 ? abort_at + 30 : 1700;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wc = 0; dc = 0; dones = 0; n = 1; fin = 0;
      while (!fin && n < lim) begin
         if (n == 1) begin
            total++;
            if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start: got %b want 1", name, bus.busy); end
         end
         if (bus.byte_wea === 1'b1) begin
            total++;
            if (wc >= 896 || bus.byte_addr !== 10'(wc) || n != wcycle(wc)) begin
               bad++;
               $display("FAIL %s write_order: addr=%0d cycle=%0d want addr=%0d cycle=%0d", name, bus.byte_addr, n, wc, wcycle(wc));
            end
            if (wc < 896) begin
               got[wc] = bus.byte_di;
               total++;
               if (bus.byte_di !== expb[wc]) begin bad++; $display("FAIL %s byte[%0d]: got %02h want %02h", name, wc, bus.byte_di, expb[wc]); end
            end
            wc++;
         end
         if (abort_at > 0 && n == abort_at + 1) begin
            total++;
            if (bus.byte_wea !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL %s after_abort: wea=%b busy=%b want 0 0", name, bus.byte_wea, bus.busy); end
         end
         if (dc != 0 && n == dc + 1) begin
            total++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL %s after_done: busy=%b done=%b want 0 0", name, bus.busy, bus.done); end
            fin = 1;
         end
         if (bus.done === 1'b1) begin dones++; dc = n; end
         bus.start = (n == restart_at) || (start_in_final && bus.done === 1'b1);
         rst = (n == abort_at);
         @(posedge clk); #1;
         n++;
      end
      bus.start = 1'b0;
      rst = 1'b0;
      if (abort_at > 0) begin
         wexp = 0;
         for (int a = 0; a < 896; a++) if (wcycle(a) <= abort_at) wexp++;
         total++;
         if (dones != 0 || wc != wexp) begin bad++; $display("FAIL %s abort_summary: dones=%0d writes=%0d want 0 %0d", name, dones, wc, wexp); end
      end else begin
         total++;
         if (wc != 896 || dc != 1537 || dones != 1) begin bad++; $display("FAIL %s run_summary: writes=%0d done_cycle=%0d dones=%0d want 896 1537 1", name, wc, dc, dones); end
      end
   endtask
   task automatic check_group(input string name, input int g, input logic [55:0] want);
      for (int b = 0; b < 7; b++) begin
         total++;
         if (got[7 * g + b] !== want[55 - 8 * b -: 8]) begin bad++; $display("FAIL %s group%0d_b%0d: got %02h want %02h", name, g, b, got[7 * g + b], want[55 - 8 * b -: 8]); end
      end
   endtask
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; bus.start = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({bus.busy, bus.done, bus.byte_wea, bus.byte_addr, bus.byte_di, bus.poly_addra} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: busy=%b done=%b wea=%b addr=%0d di=%02h pa=%0d want all 0", bus.busy, bus.done, bus.byte_wea, bus.byte_addr, bus.byte_di, bus.poly_addra);
      end
      rst = 1'b0; bus.start = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if (bus.busy !== 1'b0 || bus.byte_wea !== 1'b0 || bus.poly_addra !== '0) begin bad++; $display("FAIL start_with_rst: busy=%b wea=%b pa=%0d want 0 0 0", bus.busy, bus.byte_wea, bus.poly_addra); end
   endtask
   task automatic test_zeros();
      for (int n = 0; n < 512; n++) mem[n] = '0;
      run("zeros", -1, -1, 0);
   endtask
   task automatic test_ramp();
      for (int n = 0; n < 512; n++) mem[n] = 16'(n);
      run("ramp", -1, -1, 0);
      check_group("ramp", 0, 56'h00_40_00_20_00_0C_00);
   endtask
   task automatic test_q_minus_1();
      for (int n = 0; n < 512; n++) mem[n] = 16'h3000;
      run("q_minus_1", -1, -1, 0);
      check_group("q_minus_1", 0, 56'h00_30_00_0C_00_03_C0);
      check_group("q_minus_1", 127, 56'h00_30_00_0C_00_03_C0);
   endtask
   task automatic test_freeze();
      for (int n = 0; n < 512; n++) mem[n] = 16'($urandom);
      mem[0] = 16'hF001;
      mem[1] = 16'hFFFF;
      run("freeze", -1, -1, 0);
      total++;
      if (got[0] !== 8'h00 || got[1] !== 8'h80 || got[2] !== 8'hFF) begin bad++; $display("FAIL freeze_first: got %02h %02h %02h want 00 80 ff", got[0], got[1], got[2]); end
   endtask
   task automatic test_abort_restart();
      for (int n = 0; n < 512; n++) mem[n] = 16'($urandom_range(12288, 0));
      run("abort", -1, 488, 0);
      run("restart", -1, -1, 0);
   endtask
   task automatic test_back_to_back();
      int errs;
      for (int n = 0; n < 512; n++) mem[n] = 16'($urandom_range(12288, 0));
      run("busy_start", 700, -1, 1);
      errs = 0;
      for (int n = 0; n < 512; n++) begin
         int v;
         v = 0;
         for (int m = 0; m < 14; m++) v |= int'((got[(14 * n + m) / 8] >> ((14 * n + m) % 8)) & 8'd1) << m;
         if (v != int'(mem[n])) errs++;
      end
      total++;
      if (errs != 0) begin bad++; $display("FAIL round_trip: got %0d coefficient errors want 0", errs); end
      for (int n = 0; n < 512; n++) mem[n] = 16'($urandom);
      run("after_final", -1, -1, 0);
   endtask
   initial begin
      bus.start = 1'b0;
      for (int n = 0; n < 512; n++) mem[n] = '0;
      test_reset();
      test_zeros();
      test_ramp();
      test_q_minus_1();
      test_freeze();
      test_abort_restart();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/polynomial_encoder.md
Name: polynomial_encoder

Overview:
- Packs one 512-coefficient NewHope polynomial (14-bit coefficients, q = 12289) from the poly RAM into 896 bytes in the byte RAM.
- Each group of 4 coefficients becomes 7 bytes.
- Sits directly upstream of polynomial_decoder: it produces the byte image that polynomial_decoder consumes. An encode followed by a decode returns the frozen coefficients.
- Each coefficient is frozen to [0, q) before packing.

Parameters:
- Q, 12289: modulus used by the freeze step.
- FREEZE, 1: 1 = conditionally subtract Q before packing; 0 = pack c[13:0] unchanged.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to encode; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when all 896 bytes are written.
- poly_addra  output  9  coefficient read address to the poly RAM.
- poly_doa  input  16  coefficient read data; valid the cycle after poly_addra is presented; bits [15:14] ignored.
- byte_wea  output  1  byte RAM write enable.
- byte_addr  output  10  byte RAM write address, 0..895.
- byte_di  output  8  byte RAM write data.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- All outputs are registered.
- On rst: state = IDLE; busy = 0, done = 0, byte_wea = 0; poly_addra, byte_addr and byte_di = 0; group counter i = 0.
- States and transitions:
  - IDLE: go to FETCH when start = 1. start is ignored in every other state.
  - FETCH (4 cycles, sub-count k = 0..3): drive poly_addra = 4i+k.
  - CAPTURE (1 cycle): no address driven. Coefficient k is latched into register t_k on the edge ending the cycle after its address cycle, so t3 is latched at the end of CAPTURE.
  - WRITE (7 cycles, j = 0..6): byte_wea = 1, byte_addr = 7i+j, byte_di = b_j.
    - After j = 6: if i = 127, go to FINAL; else i <= i+1 and go to FETCH.
  - FINAL (1 cycle): done = 1, busy = 0, then go to IDLE with i reset to 0.
- Freeze, applied on capture with c = poly_doa[13:0]: t = (c >= Q) ? c - Q : c.
  - A 14-bit c is always < 2Q, so one subtraction fully reduces it.
- Packing (t0..t3 are the frozen coefficients 4i..4i+3):
  - b0 = t0[7:0]
  - b1 = {t1[1:0], t0[13:8]}
  - b2 = t1[9:2]
  - b3 = {t2[3:0], t1[13:10]}
  - b4 = t2[11:4]
  - b5 = {t3[5:0], t2[13:12]}
  - b6 = t3[13:6]
- Timing:
  - 12 cycles per group; the first FETCH cycle is the cycle after start is sampled.
  - The last write (byte_addr = 895) occurs 1536 cycles after start is sampled.
  - done occurs in the following cycle.
- Outside WRITE: byte_wea = 0, byte_addr = 0, byte_di = 0.
- Outside FETCH: poly_addra = 0.
- No byte address is written twice, and every address 0..895 is written exactly once per run.
- rst asserted mid-operation: the module returns to IDLE on that edge. No further writes occur and done is not asserted. A subsequent start re-encodes from i = 0.
- start asserted in the same cycle as rst: the request is dropped.
- start asserted in the FINAL cycle: ignored. The next start is accepted in IDLE.

Test Plan:
- All coefficients 0, pulse start -> 896 writes of 0x00 at addresses 0..895 in order; done pulses once, 1537 cycles after start; busy low afterwards.
- Coefficients c_j = j -> first group bytes 0x00, 0x40, 0x00, 0x20, 0x00, 0x0C, 0x00; last byte_addr = 895.
- All coefficients 12288 (0x3000) -> every group is 0x00, 0x30, 0x00, 0x0C, 0x00, 0x03, 0xC0.
- Freeze check with FREEZE = 1: coefficient 0 = 12289 packs as 0; coefficient 1 = 16383 packs as 4094; bits [15:14] = 2'b11 in poly_doa have no effect.
- rst asserted during group 40 WRITE -> byte_wea = 0 from the next cycle; no done. A restart produces a correct full image.
- Round trip: random coefficients < Q -> encode, then polynomial_decoder on the byte image -> all 512 coefficients identical. A second start pulsed while busy causes no change in output or cycle count.
